// File: rtl/board_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// board_pkg : colour type, card palette and FSM states for board_ram
// Rev 1.0
// ------------------------------------------------------------------
package board_pkg;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t EMPTY = 8'h00;

  localparam int NPAL = 32;

  // Distinct non-zero colours; index 0 is {r=4, g=4, b=3}.
  localparam rgb332_t PALETTE [NPAL] = '{
    8'h93, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hFF,
    8'h49, 8'h92, 8'h6D, 8'hB6, 8'hDB, 8'h24, 8'h48, 8'h6C,
    8'h90, 8'hB4, 8'hD8, 8'h0C, 8'h14, 8'h18, 8'h60, 8'hA0,
    8'hC0, 8'h01, 8'h02, 8'h80, 8'h20, 8'h04, 8'h08, 8'h10
  };

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_CHK  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/board_layout_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// board_layout_gen : seeded stride walk producing the layout writes
// Rev 1.0
// ------------------------------------------------------------------
module board_layout_gen
  import board_pkg::*;
#(
  parameter int NCELLS = 36,
  parameter int AW     = 6,
  parameter int STRIDE = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] seed_i,
  input  logic          step_i,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          last_o
);

  localparam logic [AW:0]   C_NCELLS = (AW+1)'(NCELLS);
  localparam logic [AW:0]   C_STRIDE = (AW+1)'(STRIDE);
  localparam logic [AW-1:0] C_LAST   = AW'(NCELLS - 1);

  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] p_q, p_d;
  logic [AW:0]   w_sum;
  logic [4:0]    w_pidx;

  always_comb begin
    w_sum = {1'b0, p_q} + C_STRIDE;
    k_d   = k_q;
    p_d   = p_q;
    if (load_i) begin
      k_d = '0;
      p_d = AW'(int'(seed_i) % NCELLS);
    end else if (step_i) begin
      k_d = (k_q == C_LAST) ? '0 : k_q + AW'(1);
      // STRIDE < NCELLS, so a single conditional subtract keeps p in range
      p_d = (w_sum >= C_NCELLS) ? AW'(w_sum - C_NCELLS) : AW'(w_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
      p_q <= '0;
    end else begin
      k_q <= k_d;
      p_q <= p_d;
    end
  end

  assign w_pidx    = 5'(p_q >> 1);
  assign wr_addr_o = k_q;
  assign wr_data_o = PALETTE[w_pidx];
  assign last_o    = (k_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/board_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// board_ram : writable, self-initialising card-colour board memory
// Rev 1.0
// ------------------------------------------------------------------
module board_ram
  import board_pkg::*;
#(
  parameter int ROWS   = 6,
  parameter int COLS   = 6,
  parameter int NCELLS = ROWS * COLS,
  parameter int AW     = 6,
  parameter int STRIDE = 7,
  parameter int CNTW   = $clog2(NCELLS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_start,
  input  logic [AW-1:0]   init_seed,
  output logic            init_busy,
  input  logic [AW-1:0]   disp_addr,
  output logic [2:0]      disp_r,
  output logic [2:0]      disp_g,
  output logic [1:0]      disp_b,
  input  logic [AW-1:0]   alg_addr_a,
  input  logic [AW-1:0]   alg_addr_b,
  output logic [7:0]      alg_color_a,
  output logic [7:0]      alg_color_b,
  output logic            alg_match,
  input  logic            clr_valid,
  input  logic [AW-1:0]   clr_addr_a,
  input  logic [AW-1:0]   clr_addr_b,
  output logic            clr_ready,
  output logic            clr_done,
  output logic            clr_err,
  output logic [CNTW-1:0] remaining,
  output logic            board_empty
);

  localparam logic [CNTW-1:0] C_FULL = CNTW'(NCELLS);

  logic [7:0]      mem_q [NCELLS];
  state_e          state_q;
  logic            init_busy_q, clr_ready_q, done_q, err_q;
  logic [AW-1:0]   chk_a_q, chk_b_q;
  logic [CNTW-1:0] remaining_q;
  logic [7:0]      disp_q, alg_a_q, alg_b_q;
  logic            match_q;

  logic            w_gen_load, w_gen_step, w_gen_last;
  logic [AW-1:0]   w_wr_addr;
  logic [7:0]      w_wr_data;
  logic [7:0]      w_disp, w_ca, w_cb, w_ka, w_kb;
  logic            w_accept;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NCELLS;
  endfunction

  // Out-of-range addresses read as an empty cell.
  function automatic logic [7:0] rd_cell(input logic [AW-1:0] a);
    return in_range(a) ? mem_q[a] : EMPTY;
  endfunction

  assign w_gen_load = (state_q == ST_IDLE) && init_start;
  assign w_gen_step = (state_q == ST_INIT);

  board_layout_gen #(
    .NCELLS (NCELLS),
    .AW     (AW),
    .STRIDE (STRIDE)
  ) u_layout (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_gen_load),
    .seed_i    (init_seed),
    .step_i    (w_gen_step),
    .wr_addr_o (w_wr_addr),
    .wr_data_o (w_wr_data),
    .last_o    (w_gen_last)
  );

  always_comb begin
    w_disp   = rd_cell(disp_addr);
    w_ca     = rd_cell(alg_addr_a);
    w_cb     = rd_cell(alg_addr_b);
    w_ka     = rd_cell(chk_a_q);
    w_kb     = rd_cell(chk_b_q);
    w_accept = (chk_a_q != chk_b_q) && in_range(chk_a_q) && in_range(chk_b_q) &&
               (w_ka != EMPTY) && (w_kb != EMPTY) && (w_ka == w_kb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCELLS; i++) mem_q[i] <= EMPTY;
      state_q     <= ST_INIT;
      init_busy_q <= 1'b1;
      clr_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      chk_a_q     <= '0;
      chk_b_q     <= '0;
      remaining_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_INIT: begin
          mem_q[w_wr_addr] <= w_wr_data;
          if (w_gen_last) begin
            state_q     <= ST_IDLE;
            init_busy_q <= 1'b0;
            clr_ready_q <= 1'b1;
            remaining_q <= C_FULL;
          end
        end
        ST_IDLE: begin
          if (init_start) begin
            state_q     <= ST_INIT;
            init_busy_q <= 1'b1;
            clr_ready_q <= 1'b0;
          end else if (clr_valid) begin
            chk_a_q     <= clr_addr_a;
            chk_b_q     <= clr_addr_b;
            state_q     <= ST_CHK;
            clr_ready_q <= 1'b0;
          end
        end
        ST_CHK: begin
          if (w_accept) begin
            mem_q[chk_a_q] <= EMPTY;
            mem_q[chk_b_q] <= EMPTY;
            remaining_q    <= remaining_q - CNTW'(2);
            done_q         <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q     <= ST_IDLE;
          clr_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          init_busy_q <= 1'b0;
          clr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= EMPTY;
      alg_a_q <= EMPTY;
      alg_b_q <= EMPTY;
      match_q <= 1'b0;
    end else begin
      disp_q  <= w_disp;
      alg_a_q <= w_ca;
      alg_b_q <= w_cb;
      match_q <= (w_ca == w_cb) && (w_ca != EMPTY) && (alg_addr_a != alg_addr_b);
    end
  end

  assign init_busy   = init_busy_q;
  assign clr_ready   = clr_ready_q;
  assign clr_done    = done_q;
  assign clr_err     = err_q;
  assign remaining   = remaining_q;
  assign board_empty = (remaining_q == '0) && (state_q == ST_IDLE);
  assign disp_r      = disp_q[7:5];
  assign disp_g      = disp_q[4:2];
  assign disp_b      = disp_q[1:0];
  assign alg_color_a = alg_a_q;
  assign alg_color_b = alg_b_q;
  assign alg_match   = match_q;

endmodule
`default_nettype wire

// File: tb/tb_board_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_board_ram : randomized self-checking bench for board_ram
// Rev 1.0
// ------------------------------------------------------------------
module tb_board_ram;
  import board_pkg::*;

  localparam int N    = 36;
  localparam int AW   = 6;
  localparam int STR  = 7;
  localparam int CNTW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            init_start = 1'b0;
  logic [AW-1:0]   init_seed = '0;
  logic            init_busy;
  logic [AW-1:0]   disp_addr = '0;
  logic [2:0]      disp_r, disp_g;
  logic [1:0]      disp_b;
  logic [AW-1:0]   alg_addr_a = '0, alg_addr_b = '0;
  logic [7:0]      alg_color_a, alg_color_b;
  logic            alg_match;
  logic            clr_valid = 1'b0;
  logic [AW-1:0]   clr_addr_a = '0, clr_addr_b = '0;
  logic            clr_ready, clr_done, clr_err;
  logic [CNTW-1:0] remaining;
  logic            board_empty;

  board_ram dut (
    .clk(clk), .rst(rst), .init_start(init_start), .init_seed(init_seed),
    .init_busy(init_busy), .disp_addr(disp_addr), .disp_r(disp_r),
    .disp_g(disp_g), .disp_b(disp_b), .alg_addr_a(alg_addr_a),
    .alg_addr_b(alg_addr_b), .alg_color_a(alg_color_a),
    .alg_color_b(alg_color_b), .alg_match(alg_match), .clr_valid(clr_valid),
    .clr_addr_a(clr_addr_a), .clr_addr_b(clr_addr_b), .clr_ready(clr_ready),
    .clr_done(clr_done), .clr_err(clr_err), .remaining(remaining),
    .board_empty(board_empty)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] model [N];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference layout: cell k holds palette entry ((seed + k*STRIDE) mod N) / 2.
  task automatic model_init(input int seed);
    for (int k = 0; k < N; k++) model[k] = PALETTE[((seed % N) + k * STR) % N / 2];
  endtask

  function automatic logic [7:0] exp_col(input int a);
    return (a < N) ? model[a] : 8'h00;
  endfunction

  function automatic int live_cells();
    int c = 0;
    for (int i = 0; i < N; i++) if (model[i] != 8'h00) c++;
    return c;
  endfunction

  function automatic int partner(input int a);
    if (a < N && model[a] != 8'h00)
      for (int j = 0; j < N; j++) if (j != a && model[j] == model[a]) return j;
    return a;
  endfunction

  // Counts edges since start_cyc until init_busy falls; clr_ready must stay low meanwhile.
  task automatic wait_init(input string tag, input int start_cyc);
    int   g = 0;
    logic ready_bad = 1'b0;
    while (init_busy === 1'b1 && g < 200) begin
      if (clr_ready !== 1'b0) ready_bad = 1'b1;
      tick();
      g++;
    end
    check({tag, "_cycles"}, 32'(cyc - start_cyc), 32'(N));
    check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
    check({tag, "_remaining"}, 32'(remaining), 32'(N));
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < N; a++) begin
      disp_addr = AW'(a);
      tick();
      check(tag, {24'd0, disp_r, disp_g, disp_b}, 32'(model[a]));
    end
  endtask

  task automatic do_clear(input int a, input int b);
    int   g = 0;
    logic acc;
    while (clr_ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    acc = (a != b) && (a < N) && (b < N) && exp_col(a) != 8'h00 && exp_col(a) == exp_col(b);
    clr_valid  = 1'b1;
    clr_addr_a = AW'(a);
    clr_addr_b = AW'(b);
    tick();
    clr_valid = 1'b0;
    check("clr_ready_chk", 32'(clr_ready), 32'd0);
    tick();
    if (acc) begin
      model[a] = 8'h00;
      model[b] = 8'h00;
    end
    check("clr_done", 32'(clr_done), 32'(acc));
    check("clr_err", 32'(clr_err), 32'(!acc));
    check("clr_ready_pulse", 32'(clr_ready), 32'd1);
    check("remaining", 32'(remaining), 32'(live_cells()));
    tick();
    check("clr_pulse_end", {30'd0, clr_done, clr_err}, 32'd0);
  endtask

  task automatic alg_check(input int a, input int b);
    logic [7:0] ca, cb;
    ca = exp_col(a);
    cb = exp_col(b);
    alg_addr_a = AW'(a);
    alg_addr_b = AW'(b);
    tick();
    check("alg_color_a", 32'(alg_color_a), 32'(ca));
    check("alg_color_b", 32'(alg_color_b), 32'(cb));
    check("alg_match", 32'(alg_match), 32'((ca == cb) && (ca != 8'h00) && (a != b)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rc, a, b, s;

    // Reset and seed-0 layout
    tick();
    rst = 1'b0;
    rc  = cyc;
    check("rst_busy", 32'(init_busy), 32'd1);
    check("rst_ready", 32'(clr_ready), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_disp", {24'd0, disp_r, disp_g, disp_b}, 32'd0);
    check("rst_outs", {28'd0, alg_match, clr_done, clr_err, board_empty}, 32'd0);
    wait_init("init0", rc);
    model_init(0);
    check("init0_empty", 32'(board_empty), 32'd0);
    disp_addr = 6'd0;
    tick();
    check("cell0_r4g4b3", {24'd0, disp_r, disp_g, disp_b}, 32'h93);
    sweep("layout_seed0");
    disp_addr = 6'd45;
    tick();
    check("disp_oob", {24'd0, disp_r, disp_g, disp_b}, 32'd0);

    // Algorithm port
    alg_check(0, 31);
    check("match_0_31", 32'(alg_match), 32'd1);
    alg_check(0, 1);
    alg_check(0, 0);
    alg_check(40, 50);
    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 40);
      b = $urandom_range(0, 1) ? partner(a) : $urandom_range(0, 40);
      alg_check(a, b);
    end

    // Directed clears
    do_clear(0, 31);
    check("rem_34", 32'(remaining), 32'd34);
    do_clear(0, 31);
    do_clear(0, 1);
    do_clear(2, 3);
    do_clear(5, 5);
    do_clear(40, 0);
    check("rem_still_34", 32'(remaining), 32'd34);
    sweep("after_rejects");

    // Random clears, then clear everything left
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 40);
      b = $urandom_range(0, 1) ? partner(a) : $urandom_range(0, 40);
      do_clear(a, b);
    end
    for (int i = 0; i < N; i++) if (model[i] != 8'h00) do_clear(i, partner(i));
    check("all_clear_rem", 32'(remaining), 32'd0);
    check("board_empty", 32'(board_empty), 32'd1);

    // init_start wins over a simultaneous clr_valid; seed 5
    clr_valid  = 1'b1;
    clr_addr_a = 6'd1;
    clr_addr_b = 6'd2;
    init_start = 1'b1;
    init_seed  = 6'd5;
    tick();
    rc = cyc;
    init_start = 1'b0;
    clr_valid  = 1'b0;
    check("start_busy", 32'(init_busy), 32'd1);
    check("start_empty_low", 32'(board_empty), 32'd0);
    tick();
    check("start_no_chk", {30'd0, clr_done, clr_err}, 32'd0);
    wait_init("init5", rc);
    model_init(5);
    disp_addr = 6'd0;
    tick();
    check("seed5_cell0", {24'd0, disp_r, disp_g, disp_b}, 32'(PALETTE[2]));
    sweep("layout_seed5");

    // Random seed, including seeds >= N
    s = $urandom_range(36, 63);
    init_seed  = AW'(s);
    init_start = 1'b1;
    tick();
    rc = cyc;
    init_start = 1'b0;
    wait_init("init_rand", rc);
    model_init(s);
    sweep("layout_rand");

    // Reset during CHK
    do_clear(0, partner(0));
    a = partner(1);
    clr_valid  = 1'b1;
    clr_addr_a = 6'd1;
    clr_addr_b = AW'(a);
    tick();
    clr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rc  = cyc;
    check("rstchk_busy", 32'(init_busy), 32'd1);
    check("rstchk_rem", 32'(remaining), 32'd0);
    check("rstchk_pulses", {30'd0, clr_done, clr_err}, 32'd0);
    alg_addr_a = 6'd0;
    alg_addr_b = 6'd35;
    disp_addr  = 6'd20;
    tick();
    check("rstchk_cell0", 32'(alg_color_a), 32'd0);
    check("rstchk_cell35", 32'(alg_color_b), 32'd0);
    check("rstchk_cell20", {24'd0, disp_r, disp_g, disp_b}, 32'd0);
    wait_init("rstchk_init", rc);
    model_init(0);
    sweep("rstchk_layout");

    // Reset in INIT cycle 10, clr_valid held through the following INIT
    init_seed  = 6'd9;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rc  = cyc;
    clr_valid  = 1'b1;
    clr_addr_a = 6'd0;
    clr_addr_b = 6'd31;
    alg_addr_a = 6'd3;
    alg_addr_b = 6'd4;
    tick();
    check("rstinit_cell3", 32'(alg_color_a), 32'd0);
    check("rstinit_cell4", 32'(alg_color_b), 32'd0);
    wait_init("rstinit_init", rc);
    model_init(0);
    check("held_not_early", {30'd0, clr_done, clr_err}, 32'd0);
    check("held_ready", 32'(clr_ready), 32'd1);
    tick();
    clr_valid = 1'b0;
    check("held_chk", 32'(clr_ready), 32'd0);
    tick();
    model[0]  = 8'h00;
    model[31] = 8'h00;
    check("held_done", 32'(clr_done), 32'd1);
    check("held_rem", 32'(remaining), 32'd34);
    alg_check(0, 31);
    sweep("final_layout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_ram.md
Name: board_ram

Overview:
- Writable, self-initialising successor to the fixed card-colour table.
- Holds ROWS×COLS cells of rgb332 colour and generates a pair-complete layout from a seed.
- Serves a display read port and a two-address algorithm port with a registered match flag.
- Executes validated "clear pair" commands and tracks remaining cards. Colour 0 (black) is reserved to mean an empty cell.

Parameters:
- ROWS, 6, board rows
- COLS, 6, board columns
- NCELLS, ROWS*COLS, cell count; must be even and ≤ 64
- AW, 6, address width; 2**AW ≥ NCELLS
- STRIDE, 7, layout permutation step; must be coprime with NCELLS
- CNTW, $clog2(NCELLS+1), remaining-counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- init_start  in  1  start re-layout (accepted only when idle)
- init_seed  in  AW  layout seed, sampled with init_start
- init_busy  out  1  high while layout is being written
- disp_addr  in  AW  display read address
- disp_r / disp_g / disp_b  out  3/3/2  display colour, 1-cycle latency
- alg_addr_a, alg_addr_b  in  AW  algorithm read addresses
- alg_color_a, alg_color_b  out  8  {r,g,b} colours, 1-cycle latency
- alg_match  out  1  registered: colours equal, both non-zero, addresses differ
- clr_valid  in  1  clear-pair request
- clr_addr_a, clr_addr_b  in  AW  cells to clear
- clr_ready  out  1  high in IDLE
- clr_done  out  1  1-cycle pulse: pair cleared
- clr_err  out  1  1-cycle pulse: request rejected
- remaining  out  CNTW  non-empty cell count
- board_empty  out  1  remaining==0 and state IDLE

Behaviour:
- Reset (clk edge with rst=1):
  - All cells set to 0; all read outputs, alg_match, clr_done, clr_err and remaining set to 0.
  - State goes to INIT with p = 0 (seed 0); init_busy = 1, clr_ready = 0.
  - Reset mid-INIT or mid-CHK aborts the operation with the same result.
- FSM states are INIT, IDLE and CHK.
- INIT:
  - On cycle k (k = 0..NCELLS-1), write cell k ← PALETTE[p>>1], then update p ← (p+STRIDE) mod NCELLS by conditional subtract (no multiplier).
  - Because the permutation is a bijection, each palette index lands in exactly two cells.
  - Initial p = init_seed mod NCELLS.
  - After the last write: remaining = NCELLS, state → IDLE, init_busy = 0. INIT takes exactly NCELLS cycles.
- IDLE:
  - init_start has priority over clr_valid; init_start moves the state to INIT.
  - Otherwise clr_valid && clr_ready latches both addresses and moves to CHK.
  - init_start and clr_valid are ignored outside IDLE; requesters hold clr_valid until clr_ready.
- CHK is a single cycle. Accept when all hold: a≠b, both < NCELLS, both non-zero, colours equal.
  - Accept: both cells ← 0 and remaining −= 2 at the end of CHK; clr_done pulses in the next cycle.
  - Reject: no write; clr_err pulses in the next cycle.
  - State returns to IDLE in either case, so clr_ready is high in the same cycle as the pulse.
- Read ports:
  - Registered from the array state before the edge; a read of a cell written on the same edge returns the old value.
  - Out-of-range addresses read 0.
  - Reads stay live during INIT and CHK.
- alg_match is registered alongside alg_color_a and alg_color_b.

Decomposition:
- Package board_pkg:
  - RGB332 colour typedef and EMPTY = 8'h00.
  - PALETTE[0..31] of distinct non-zero rgb332 constants; PALETTE[0] = {3'd4, 3'd4, 2'd3}.
  - FSM state enum.
- Sub-module board_layout_gen:
  - The seeded stride counter (k, p); emits write address, write data and a last flag.
  - Keeps the permutation arithmetic separately verifiable.

Test Plan:
- Reset, then 36 cycles → init_busy falls on cycle 36; remaining = 36; disp_addr = 0 reads r4 g4 b3; cells 0 and 31 read equal colours (seed 0, stride 7).
- Seed 0, alg_addr_a = 0, alg_addr_b = 31 → alg_match = 1 one cycle later. With alg_addr_b = 1 → 0. With a = b = 0 → 0.
- Clear (0, 31) → clr_done pulse 2 cycles after acceptance; remaining = 34; both cells read 0; repeating the clear → clr_err, remaining stays 34.
- Clear (0, 1) with mismatched colours, clear (5, 5), clear (40, 0) → clr_err each time; no cell changes.
- Clear all 18 pairs → remaining = 0 and board_empty = 1; init_start with seed 5 → cell 0 reads PALETTE[2]; remaining returns to 36.
- Assert rst during CHK and during INIT cycle 10 → all cells 0 the cycle after; full re-init completes 36 cycles later with the seed-0 layout; clr_valid held during INIT is not accepted until clr_ready.
